bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit multiplexed 7-segment display stage.
- Drives its ones/tens/hundreds/thousands BCD inputs from a binary value, such as a counter or switch bank.
- Start/done handshake. Output digits stay stable during a conversion, so the display never shows partial results.

---
 rtl/bin2bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/done handshake.
// Optional build macro LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bin2bcd_seq #(
  parameter int unsigned BIN_W   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned     CNT_W   = $clog2(BIN_W);
  localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;
  localparam bit              CAN_OVF = (BIN_MAX > 64'(MAX_VAL));

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [BIN_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_cand;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [15:0]      r_digits;
  logic             w_ovf_in;
  logic [15:0]      w_adj;
  logic [15:0]      w_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Narrow inputs can never exceed MAX_VAL, so the flag folds to zero
  assign w_ovf_in = CAN_OVF ? (64'(bin) > 64'(MAX_VAL)) : 1'b0;

  // Per-nibble add-3, no carry between nibbles
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  // Value presented on the DONE cycle: saturation, then optional blanking
  always_comb begin
    w_result = r_ovf_cand ? 16'h9999 : r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
    if (!r_ovf_cand && (w_result[15:12] == 4'h0)) begin
      w_result[15:12] = 4'hF;
      if (w_result[11:8] == 4'h0) begin
        w_result[11:8] = 4'hF;
        if (w_result[7:4] == 4'h0) w_result[7:4] = 4'hF;
      end
    end
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_cand <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_digits   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin      <= bin;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(BIN_W - 1);
            r_ovf_cand <= w_ovf_in;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[14:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          r_digits <= w_result;
          r_ovf    <= r_ovf_cand;
        end
        default: ;
      endcase
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign thousands = r_digits[15:12];
  assign hundreds  = r_digits[11:8];
  assign tens      = r_digits[7:4];
  assign ones      = r_digits[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed conversions, latency/hold/handshake checks.
// Expected digits follow the LEADING_ZERO_BLANK_EN build macro when it is defined.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [3:0]  ones, tens, hundreds, thousands;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          n_exp   = 0;
  logic [15:0] last_exp = 16'h0000;

  bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [15:0] blank(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (r[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
    return r;
  endfunction
`endif

  // Monitor: pops the scoreboard whenever the DUT signals done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("digits", 32'({thousands, hundreds, tens, ones}), 32'(e.d));
          chk("ovf", 32'(ovf), 32'(e.o));
        end
      end
    end
  end

  // One conversion; inject>0 pulses a second start, abort>0 asserts rst at that cycle
  task automatic conv(input logic [13:0] b, input logic [15:0] exp_d, input logic exp_o,
                      input int inject, input int abort);
    exp_t e;
    int   lat;
    bit   held_ok;
    e.d = exp_d;
    e.o = exp_o;
`ifdef LEADING_ZERO_BLANK_EN
    if (!exp_o) e.d = blank(exp_d);
`endif
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    if (abort == 0) begin
      sb_q.push_back(e);
      n_exp++;
    end
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    held_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == inject) begin
        start = 1'b1;
        bin   = 14'd7890;
      end
      if (i == abort) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (i == abort) begin
        chk("abort_digits", 32'({thousands, hundreds, tens, ones}), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        last_exp = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if ({thousands, hundreds, tens, ones} !== last_exp) held_ok = 1'b0;
    end
    chk("latency", 32'(lat), 32'(15));
    chk("held_during_busy", 32'(held_ok), 32'(1));
    chk("busy_at_done", 32'(busy), 32'(1));
    last_exp = e.d;
    @(posedge clk);
    #1;
    chk("busy_after", 32'(busy), 32'(0));
    chk("done_single", 32'(done), 32'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    bin   = 14'd1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_digits", 32'({thousands, hundreds, tens, ones}), 32'(0));
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_rst", 32'(busy), 32'(0));

    conv(14'd1234,  16'h1234, 1'b0, 0, 0);
    conv(14'd9999,  16'h9999, 1'b0, 0, 0);
    conv(14'h2710,  16'h9999, 1'b1, 0, 0);
    conv(14'd0,     16'h0000, 1'b0, 0, 0);
    conv(14'd56,    16'h0056, 1'b0, 5, 0);
    conv(14'd4321,  16'h4321, 1'b0, 0, 8);
    conv(14'd4321,  16'h4321, 1'b0, 0, 0);
    conv(14'd42,    16'h0042, 1'b0, 0, 0);
    conv(14'd1005,  16'h1005, 1'b0, 0, 0);
    conv(14'd12000, 16'h9999, 1'b1, 0, 0);
    conv(14'd10,    16'h0010, 1'b0, 0, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("done_count", 32'(n_done), 32'(n_exp));
    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
